// File: rtl/gpu_pkg.sv
// Shared types and default sizing for the GPU pixel path.
package gpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rle_state_t;

  localparam int DEF_VW       = 6;
  localparam int DEF_CW       = 10;
  localparam int DEF_H_ACTIVE = 640;

endpackage

// File: rtl/rle_pixel_stream_if.sv
// Run input and pixel output handshakes of the RLE pixel expander.
interface rle_pixel_stream_if
  import gpu_pkg::*;
#(
  parameter int VW = DEF_VW,
  parameter int CW = DEF_CW
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic [VW-1:0] in_value;
  logic          pix_valid;
  logic          pix_ready;
  logic [VW-1:0] pix_value;
  logic          pix_last;

  modport master (
    output in_valid, in_count, in_value, pix_ready,
    input  in_ready, pix_valid, pix_value, pix_last
  );

  modport slave (
    input  in_valid, in_count, in_value, pix_ready,
    output in_ready, pix_valid, pix_value, pix_last
  );
endinterface

// File: rtl/rle_run_slot.sv
// One-entry {count,value} prefetch register; accepts only when empty so an
// accept and a take can never coincide.
module rle_run_slot
  import gpu_pkg::*;
#(
  parameter int VW = DEF_VW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [CW-1:0] in_count,
  input  logic [VW-1:0] in_value,
  output logic          in_ready,
  input  logic          take,
  output logic          nxt_valid,
  output logic [CW-1:0] nxt_cnt,
  output logic [VW-1:0] nxt_val
);
  logic          nxt_valid_q, nxt_valid_d;
  logic [CW-1:0] nxt_cnt_q, nxt_cnt_d;
  logic [VW-1:0] nxt_val_q, nxt_val_d;
  logic          accept;

  assign in_ready = !nxt_valid_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nxt_valid_d = nxt_valid_q;
    nxt_cnt_d   = nxt_cnt_q;
    nxt_val_d   = nxt_val_q;
    if (flush) begin
      nxt_valid_d = 1'b0;
    end else if (accept) begin
      nxt_valid_d = 1'b1;
      nxt_cnt_d   = in_count;
      nxt_val_d   = in_value;
    end else if (take) begin
      nxt_valid_d = 1'b0;
    end
  end

  // NOTE: the payload is reset too; it is only one entry, and keeps X out of downstream compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_valid_q <= 1'b0;
      nxt_cnt_q   <= '0;
      nxt_val_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      nxt_valid_q <= nxt_valid_d;
      nxt_cnt_q   <= nxt_cnt_d;
      nxt_val_q   <= nxt_val_d;
    end
  end

  assign nxt_valid = nxt_valid_q;
  assign nxt_cnt   = nxt_cnt_q;
  assign nxt_val   = nxt_val_q;
endmodule

// File: rtl/rle_pixel_stream.sv
// Run-length pixel expander: {count,value} runs in, count copies of value out.
// Define RLE_LINE_COUNT_EN to add the column counter that drives line_end.
module rle_pixel_stream
  import gpu_pkg::*;
#(
  parameter int VW       = DEF_VW,
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  rle_pixel_stream_if.slave   bus,
  output logic                run_done,
  output logic                line_end,
  output logic                busy
);
  logic          nxt_valid;
  logic [CW-1:0] nxt_cnt;
  logic [VW-1:0] nxt_val;
  logic          take;

  rle_run_slot #(.VW(VW), .CW(CW)) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .in_count (bus.in_count),
    .in_value (bus.in_value),
    .in_ready (bus.in_ready),
    .take     (take),
    .nxt_valid(nxt_valid),
    .nxt_cnt  (nxt_cnt),
    .nxt_val  (nxt_val)
  );

  rle_state_t    state_q, state_d;
  logic [CW-1:0] cur_rem_q, cur_rem_d;
  logic [VW-1:0] cur_val_q, cur_val_d;
  logic          run_done_q, run_done_d;
  logic          beat, last_beat, load_pt;

  assign beat      = (state_q == EMIT) && bus.pix_ready;
  assign last_beat = beat && (cur_rem_q == CW'(1));
  assign load_pt   = (state_q == IDLE) || last_beat;
  assign take      = load_pt && nxt_valid;

  always_comb begin
    state_d    = state_q;
    cur_rem_d  = cur_rem_q;
    cur_val_d  = cur_val_q;
    run_done_d = last_beat;
    if (beat && !last_beat) begin
      cur_rem_d = cur_rem_q - CW'(1);
    end
    if (load_pt) begin
      // A zero-count run is consumed from the slot but never emitted.
      if (nxt_valid && (nxt_cnt != '0)) begin
        state_d   = EMIT;
        cur_rem_d = nxt_cnt;
        cur_val_d = nxt_val;
      end else begin
        state_d   = IDLE;
        cur_rem_d = '0;
      end
    end
    if (flush) begin
      state_d    = IDLE;
      cur_rem_d  = '0;
      run_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_rem_q  <= '0;
      cur_val_q  <= '0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_rem_q  <= cur_rem_d;
      cur_val_q  <= cur_val_d;
      run_done_q <= run_done_d;
    end
  end

  assign bus.pix_valid = (state_q == EMIT);
  assign bus.pix_value = cur_val_q;
  assign bus.pix_last  = bus.pix_valid && (cur_rem_q == CW'(1));
  assign run_done      = run_done_q;
  assign busy          = (state_q == EMIT) || nxt_valid;

`ifdef RLE_LINE_COUNT_EN
  localparam int COLW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic [COLW-1:0] col_q, col_d;
  logic            col_wrap;

  assign col_wrap = (col_q == COLW'(H_ACTIVE - 1));

  // Column tracks accepted beats only; runs may straddle a line boundary.
  always_comb begin
    col_d = col_q;
    if (flush) begin
      col_d = '0;
    end else if (beat) begin
      col_d = col_wrap ? '0 : col_q + COLW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign line_end = bus.pix_valid && col_wrap;
`else
  logic unused_h_active;
  assign unused_h_active = ^H_ACTIVE;
  assign line_end        = 1'b0;
`endif
endmodule
